tile_pixel_fetch: RTL and testbench
===================================

// Module: tile_pixel_fetch
// PURPOSE
//  Consumes the per-pixel tile coordinates produced by the screen-centering/tile-address stage.
//  Reads the tile code from the playfield RAM, then the 2-bitplane pattern row from the tile ROM.
//  Emits a 2-bit colour index plus an aligned blank flag to the palette/VGA output stage.
//  Owns the single playfield RAM port and grants leftover cycles to the CPU via req/gnt.
// PARAMETERS
//  PF_AW    10  playfield RAM address width (32 cols x 30 rows used, 1024 locations)
//  CODE_W    8  tile code width; ROM address = {code, tileRow}, so ROM_AW = CODE_W+3
// PORTS
//  clk         in   1   system clock; all state on rising edge
//  rst_b       in   1   asynchronous active-low reset
//  pix_en      in   1   one-clock strobe: tile inputs below are valid this cycle
//  blank_in    in   1   pixel is outside the playfield window
//  tile_addr   in   10  playfield index {row[4:0],col[4:0]}
//  tile_row    in   3   row within tile
//  tile_col    in   3   column within tile
//  pf_addr     out  10  playfield RAM address (1-clk synchronous read)
//  pf_we       out  1   playfield RAM write enable
//  pf_wdata    out  8   playfield RAM write data
//  pf_rdata    in   8   playfield RAM read data, valid the clock after the address
//  rom_addr    out  11  tile ROM address {code, tile_row}
//  rom_rdata   in   16  [15:8] plane1, [7:0] plane0; valid the clock after the address
//  cpu_req     in   1   CPU playfield access request; held until cpu_gnt
//  cpu_we      in   1   1 = write, 0 = read; stable while cpu_req
//  cpu_addr    in   10  CPU playfield address
//  cpu_wdata   in   8   CPU write data
//  cpu_gnt     out  1   one-clock pulse: access completed
//  cpu_rdata   out  8   read data; valid while cpu_gnt=1
//  pix_valid   out  1   pixel_idx/blank_out updated this cycle
//  pixel_idx   out  2   {plane1[bit], plane0[bit]}, bit = 7 - tile_col
//  blank_out   out  1   blank aligned with pixel_idx
// BEHAVIOUR
//  - Reset: pix_valid=0, pixel_idx=0, blank_out=1, cpu_gnt=0, cpu_rdata=0, pf_we=0.
//    All pipeline valid bits clear. An in-flight CPU grant is dropped and cpu_req must be re-honoured.
//  - Fetch slot:
//    - A cycle with pix_en=1 && blank_in=0 is a fetch slot.
//    - pf_addr = tile_addr combinationally; pf_we=0.
//  - Free slot:
//    - Any other cycle is a free slot.
//    - If cpu_req=1 and no CPU access is in flight: pf_addr=cpu_addr, pf_we=cpu_we, pf_wdata=cpu_wdata.
//    - Otherwise pf_addr holds its last value and pf_we=0.
//  - Fetch always has priority. A CPU access is never started during a fetch slot.
//  - Pipeline, sampling edge E0 where pix_en=1:
//    - S1 (after E0): latch {blank, row, col, fetch}.
//    - S1 drives rom_addr = {pf_rdata, row_s1} combinationally.
//    - S2 (after E1): latch col/blank; rom_rdata valid.
//    - At E2: register pixel_idx = blank ? 0 : {rom_rdata[8+b], rom_rdata[b]}, b = 7-col.
//      Also register blank_out and set pix_valid=1.
//  - Latency is exactly 2 clocks from pix_en to pix_valid.
//  - pix_valid is a 1-clk pulse per pix_en. Back-to-back pix_en (every clock) is fully pipelined.
//  - Between pulses, pixel_idx and blank_out hold their last values.
//  - Blanked pixels: no playfield read is issued; rom_addr is don't-care.
//    The result is pixel_idx=0, blank_out=1.
//  - CPU write:
//    - RAM written at the free-slot edge.
//    - cpu_gnt pulses the following clock.
//  - CPU read:
//    - Address issued in the free slot.
//    - cpu_rdata captures pf_rdata and cpu_gnt pulses the following clock.
//  - The master deasserts cpu_req or presents a new request after cpu_gnt.
//  - No second grant issues in the cycle cpu_gnt is high.
//  - A fetch slot arriving the cycle after a CPU read slot is legal.
//    The CPU data is captured from that cycle's pf_rdata before the fetch overwrites it.
//  - A fetch read in the same cycle a CPU write lands: impossible by construction, as both share one slot.
//  - Index width: tile_addr 0..1023 passes through unchecked. Rows 30/31 read whatever RAM holds.
// TESTING
//  1. Reset: assert rst_b=0 mid-stream -> next cycle pix_valid=0, blank_out=1, pixel_idx=0, cpu_gnt=0.
//  2. Playfield[0x021]=0x5A, ROM[{0x5A,3'd2}]=16'hF00F.
//     Drive pix_en with tile_addr=0x021, row=2, col=0..7 on consecutive clocks.
//     -> pixel_idx 2,2,2,2,1,1,1,1, each 2 clocks after its pix_en.
//  3. blank_in=1 with pix_en=1 -> pf_we=0, no fetch, pix_valid after 2 clks with pixel_idx=0, blank_out=1.
//  4. pix_en every clock plus cpu_req write 0x77 to 0x3FF -> no cpu_gnt.
//     Drop pix_en one clock -> write occurs, cpu_gnt next clock.
//     A later fetch of 0x3FF uses code 0x77.
//  5. CPU read of 0x100 (holds 0x33) in a free slot, fetch slot next clock.
//     -> cpu_rdata=0x33 with cpu_gnt; fetched pixel correct.
//  6. pix_en every other clock for 512 pixels vs software model -> zero mismatches, pix_valid count 512.

Source files
------------

// File: rtl/tile_pixel_fetch_if.sv
// CPU-side playfield access port: request/grant handshake plus address and data.
// The master holds a request stable until it sees the one-clock grant.
interface tile_pixel_fetch_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata
  );
endinterface

// File: rtl/tile_pixel_fetch.sv
// Tile pixel fetch: playfield code read, tile ROM row read, 2-bit colour index out.
// Owns the single playfield RAM port; the CPU gets whichever cycles are not fetch slots.
//
// state    | meaning
// CPU_IDLE | no CPU access in flight; a free slot may start one
// CPU_GNT  | access issued last cycle; grant pulses, read data presented
module tile_pixel_fetch #(
  parameter int PF_AW  = 10,
  parameter int CODE_W = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                pix_en,
  input  logic                blank_in,
  input  logic [PF_AW-1:0]    tile_addr,
  input  logic [2:0]          tile_row,
  input  logic [2:0]          tile_col,
  output logic [PF_AW-1:0]    pf_addr,
  output logic                pf_we,
  output logic [CODE_W-1:0]   pf_wdata,
  input  logic [CODE_W-1:0]   pf_rdata,
  output logic [CODE_W+2:0]   rom_addr,
  input  logic [15:0]         rom_rdata,
  tile_pixel_fetch_if.slave   cpu,
  output logic                pix_valid,
  output logic [1:0]          pixel_idx,
  output logic                blank_out
);

  typedef enum logic {CPU_IDLE, CPU_GNT} cpu_state_t;

  cpu_state_t        state_q, state_d;
  logic              fetch_slot;
  logic              cpu_start;
  logic [PF_AW-1:0]  pf_addr_q;
  logic [CODE_W-1:0] rdata_q;

  logic              v_s1, blank_s1;
  logic [2:0]        row_s1, col_s1;
  logic              v_s2, blank_s2;
  logic [2:0]        col_s2;
  logic [2:0]        bit_sel;

  assign fetch_slot = pix_en && !blank_in;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= CPU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cpu_start = 1'b0;
    case (state_q)
      CPU_IDLE: begin
        if (cpu.cpu_req && !fetch_slot) begin
          cpu_start = 1'b1;
          state_d   = CPU_GNT;
        end
      end
      CPU_GNT: state_d = CPU_IDLE;
      default: state_d = CPU_IDLE;
    endcase
  end

  // Fetch wins the RAM port; an idle port keeps its last address.
  always_comb begin
    pf_addr = pf_addr_q;
    pf_we   = 1'b0;
    if (fetch_slot) begin
      pf_addr = tile_addr;
    end else if (cpu_start) begin
      pf_addr = cpu.cpu_addr;
      pf_we   = cpu.cpu_we;
    end
  end

  assign pf_wdata = cpu.cpu_wdata;

  // Read data is live from the RAM during the grant cycle, then held.
  assign cpu.cpu_gnt   = (state_q == CPU_GNT);
  assign cpu.cpu_rdata = (cpu.cpu_gnt && !cpu.cpu_we) ? pf_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pf_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      pf_addr_q <= pf_addr;
      if (cpu.cpu_gnt && !cpu.cpu_we) rdata_q <= pf_rdata;
    end
  end

  assign rom_addr = {pf_rdata, row_s1};
  assign bit_sel  = 3'd7 - col_s2;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v_s1      <= 1'b0;
      blank_s1  <= 1'b1;
      row_s1    <= '0;
      col_s1    <= '0;
      v_s2      <= 1'b0;
      blank_s2  <= 1'b1;
      col_s2    <= '0;
      pix_valid <= 1'b0;
      pixel_idx <= '0;
      blank_out <= 1'b1;
    end else begin
      v_s1      <= pix_en;
      blank_s1  <= blank_in;
      row_s1    <= tile_row;
      col_s1    <= tile_col;
      v_s2      <= v_s1;
      blank_s2  <= blank_s1;
      col_s2    <= col_s1;
      pix_valid <= v_s2;
      if (v_s2) begin
        blank_out <= blank_s2;
        pixel_idx <= blank_s2 ? 2'b00 : {rom_rdata[{1'b1, bit_sel}], rom_rdata[{1'b0, bit_sel}]};
      end
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Randomized scoreboard bench for tile_pixel_fetch with bench-owned playfield RAM and tile ROM.
module tb_tile_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        pix_en = 1'b0, blank_in = 1'b0;
  logic [9:0]  tile_addr = '0;
  logic [2:0]  tile_row = '0, tile_col = '0;
  logic [9:0]  pf_addr;
  logic        pf_we;
  logic [7:0]  pf_wdata, pf_rdata;
  logic [10:0] rom_addr;
  logic [15:0] rom_rdata;
  logic        pix_valid, blank_out;
  logic [1:0]  pixel_idx;

  tile_pixel_fetch_if cpu_if ();

  tile_pixel_fetch dut (
    .clk(clk), .rst_b(rst_b), .pix_en(pix_en), .blank_in(blank_in),
    .tile_addr(tile_addr), .tile_row(tile_row), .tile_col(tile_col),
    .pf_addr(pf_addr), .pf_we(pf_we), .pf_wdata(pf_wdata), .pf_rdata(pf_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata), .cpu(cpu_if),
    .pix_valid(pix_valid), .pixel_idx(pixel_idx), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram       [1024];
  logic [7:0]  pf_shadow [1024];
  logic [15:0] rom       [2048];

  always @(posedge clk) begin
    if (pf_we) ram[pf_addr] <= pf_wdata;
    pf_rdata  <= ram[pf_addr];
    rom_rdata <= rom[rom_addr];
  end

  typedef struct {
    logic [1:0] idx;
    logic       blank;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   gnt_cnt = 0, valid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Colour index straight from the rule: plane1 bit (7-col) and plane0 bit (7-col).
  function automatic logic [1:0] model_px(input logic [9:0] a, input logic [2:0] r, input logic [2:0] c);
    int w, p1, p0;
    w  = int'(rom[{pf_shadow[a], r}]);
    p1 = (w >> (15 - int'(c))) & 1;
    p0 = (w >> (7 - int'(c))) & 1;
    return 2'(p1 * 2 + p0);
  endfunction

  always @(negedge clk) begin
    if (rst_b) begin
      if (cpu_if.cpu_gnt) gnt_cnt++;
      if (pix_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pix_valid: got pix_valid=1 expected no pending pixel (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pixel_idx", 32'(pixel_idx), 32'(e.idx));
          chk("blank_out", 32'(blank_out), 32'(e.blank));
          chk("latency",   32'(cyc),       32'(e.cyc));
        end
      end
    end
  end

  task automatic step_exp(input bit en, input bit blk, input logic [9:0] a,
                          input logic [2:0] r, input logic [2:0] c, input logic [1:0] idx);
    exp_t e;
    pix_en = en; blank_in = blk; tile_addr = a; tile_row = r; tile_col = c;
    if (en) begin
      e.idx = blk ? 2'b00 : idx;
      e.blank = blk;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    #1;
    if (en && (!blk || !cpu_if.cpu_req)) chk("slot_pf_we", 32'(pf_we), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic step(input bit en, input bit blk, input logic [9:0] a,
                      input logic [2:0] r, input logic [2:0] c);
    step_exp(en, blk, a, r, c, model_px(a, r, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 3'd0, 3'd0);
  endtask

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    pix_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_if.cpu_gnt) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [1:0] t2_exp [8];
  bit         got;
  int         g0, v0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
    ram[10'h021] = 8'h5A;
    ram[10'h100] = 8'h33;
    rom[{8'h5A, 3'd2}] = 16'hF00F;
    for (int i = 0; i < 1024; i++) pf_shadow[i] = ram[i];
    t2_exp[0] = 2; t2_exp[1] = 2; t2_exp[2] = 2; t2_exp[3] = 2;
    t2_exp[4] = 1; t2_exp[5] = 1; t2_exp[6] = 1; t2_exp[7] = 1;
    cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = '0; cpu_if.cpu_wdata = '0;

    #12;
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pixel_idx", 32'(pixel_idx), 32'd0);
    chk("rst_blank_out", 32'(blank_out), 32'd1);
    chk("rst_cpu_gnt",   32'(cpu_if.cpu_gnt), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_if.cpu_rdata), 32'd0);
    chk("rst_pf_we",     32'(pf_we), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    idle(2);

    // Known tile row, all eight columns back to back.
    for (int c = 0; c < 8; c++) step_exp(1'b1, 1'b0, 10'h021, 3'd2, 3'(c), t2_exp[c]);
    idle(4);

    // Blanked pixels.
    step(1'b1, 1'b1, 10'h021, 3'd2, 3'd0);
    step(1'b1, 1'b1, 10'h3A5, 3'd5, 3'd6);
    idle(4);

    // Reset mid-stream while pixels are in flight and a grant is pulsing.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'(i * 37), 3'(i), 3'(i + 2));
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 10'h100;
    step(1'b0, 1'b0, 10'd0, 3'd0, 3'd0);
    rst_b = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_blank_out", 32'(blank_out), 32'd1);
    chk("mid_rst_pixel_idx", 32'(pixel_idx), 32'd0);
    chk("mid_rst_cpu_gnt",   32'(cpu_if.cpu_gnt), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b1;
    wait_gnt(got);
    chk("rst_regrant_seen", 32'(got), 32'd1);
    chk("rst_regrant_rdata", 32'(cpu_if.cpu_rdata), 32'h33);
    cpu_if.cpu_req = 1'b0;
    idle(4);

    // CPU write starved by continuous fetch, then granted on the first free slot.
    g0 = gnt_cnt;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 10'h3FF; cpu_if.cpu_wdata = 8'h77;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 10'($urandom_range(0, 1022)), 3'($urandom), 3'($urandom));
    chk("starved_no_gnt", 32'(gnt_cnt - g0), 32'd0);
    step(1'b0, 1'b0, 10'd0, 3'd0, 3'd0);
    chk("write_gnt", 32'(cpu_if.cpu_gnt), 32'd1);
    cpu_if.cpu_req = 1'b0;
    pf_shadow[10'h3FF] = 8'h77;
    idle(4);
    chk("single_gnt", 32'(gnt_cnt - g0), 32'd1);
    chk("ram_written", 32'(ram[10'h3FF]), 32'h77);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 10'h3FF, 3'd6, 3'(c));
    idle(4);

    // CPU read in a free slot directly followed by a fetch slot.
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 10'h100;
    step(1'b0, 1'b0, 10'd0, 3'd0, 3'd0);
    chk("read_gnt",   32'(cpu_if.cpu_gnt), 32'd1);
    chk("read_rdata", 32'(cpu_if.cpu_rdata), 32'h33);
    cpu_if.cpu_req = 1'b0;
    step(1'b1, 1'b0, 10'h021, 3'd2, 3'd1);
    step(1'b1, 1'b0, 10'h021, 3'd2, 3'd5);
    idle(1);
    chk("read_rdata_held", 32'(cpu_if.cpu_rdata), 32'h33);
    idle(3);

    // Random stream, pix_en every other clock.
    v0 = valid_cnt;
    for (int i = 0; i < 512; i++) begin
      step(1'b1, ($urandom_range(0, 7) == 0), 10'($urandom), 3'($urandom), 3'($urandom));
      idle(1);
    end
    idle(5);
    chk("random_valid_count", 32'(valid_cnt - v0), 32'd512);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
